puf_challenge_driver: RTL and testbench
=======================================

// Module: puf_challenge_driver
// PURPOSE
//   Upstream sequencer for challenge16Arbiter; also consumes its Out.
//   Per response bit: applies a 16-bit challenge from an internal LFSR, holds
//   the arbiter DFF in reset, fires the launch edge on In, then samples the
//   synchronised Out. Packs RESP_BITS results into a word returned over a
//   valid/ready handshake.
// PARAMETERS
//   CHAL_W      16  challenge width; fixed 16 to match the arbiter chain
//   RESP_BITS   8   response bits per word, >=2
//   SETUP_CYC   4   cycles challenge is stable (In=0, arb_reset=1) before launch, >=1
//   SETTLE_CYC  8   cycles In is high before sampling; >=3 to cover the 2-flop sync
//   VOTE_N      5   evaluations per challenge (odd); used only with PUF_MAJORITY_VOTE_EN
// PORTS
//   clk         in   1          system clock
//   reset       in   1          asynchronous, active-low reset
//   start       in   1          request one response word; sampled in IDLE only
//   seed        in   CHAL_W     LFSR seed, loaded on accepted start
//   Challenge   out  CHAL_W     challenge to arbiter chain, registered
//   In          out  1          launch signal to arbiter chain, registered
//   arb_reset   out  1          reset to arbiter DFF, active-high hold, registered
//   puf_out     in   1          arbiter Out; asynchronous to clk
//   resp        out  RESP_BITS  response word; first bit in MSB
//   resp_valid  out  1          resp valid; held until resp_ready
//   resp_ready  in   1          consumer accepts resp
//   busy        out  1          high in any state other than IDLE
// BEHAVIOUR
//   Reset (async assert): state=IDLE, Challenge=0, In=0, arb_reset=1, resp=0,
//     resp_valid=0, busy=0, all counters=0, sync flops=0. Mid-operation reset
//     aborts; partial response is discarded.
//   puf_out passes through 2 flops (puf_s) before use.
//   LFSR step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//   FSM states: IDLE, LOAD, FIRE, SAMPLE, DONE.
//   IDLE: on start=1, lfsr<=(seed==0 ? 16'hACE1 : seed), bit_cnt<=0 -> LOAD.
//   LOAD: Challenge=lfsr, In=0, arb_reset=1 for SETUP_CYC cycles -> FIRE.
//   FIRE: In=1, arb_reset=0 for SETTLE_CYC cycles; Challenge held -> SAMPLE.
//   SAMPLE (1 cycle): resp_sr <= {resp_sr[RESP_BITS-2:0], puf_s}; In<=0,
//     arb_reset<=1; lfsr steps once.
//     If bit_cnt==RESP_BITS-1 -> DONE, else bit_cnt++ -> LOAD.
//   DONE: resp=resp_sr, resp_valid=1. On resp_valid&resp_ready -> IDLE;
//     resp_valid is 0 on the next cycle; resp keeps its last value.
//   Latency (no vote): start accepted at cycle t -> resp_valid at
//     t+1+RESP_BITS*(SETUP_CYC+SETTLE_CYC+1); 105 cycles at defaults.
//   start while busy: ignored. start and handshake in the same DONE cycle:
//     start ignored; it must be reasserted in IDLE.
//   Challenge changes only on the LOAD entry edge; never while In=1.
// CONFIGURATION
//   PUF_MAJORITY_VOTE_EN defined: each challenge runs LOAD/FIRE/SAMPLE VOTE_N
//     times. ones_cnt counts puf_s==1. lfsr steps and a bit shifts in only on
//     the last repeat. bit = (ones_cnt > VOTE_N/2). Latency per bit is
//     multiplied by VOTE_N.
//   Not defined: one evaluation per challenge; VOTE_N and ones_cnt are unused
//     and not synthesised.
// TESTING
//   1. puf_out=1, seed=16'h1234, start pulse -> resp=8'hFF, resp_valid at
//      start+105 cycles; busy=1 throughout.
//   2. seed=0 -> first Challenge=16'hACE1, second=16'h59C3. Check
//      In/arb_reset timing: 4 cycles setup, 8 cycles In high.
//   3. puf_out=Challenge[15] -> resp equals the bench LFSR model MSB
//      sequence, first bit in resp[7].
//   4. resp_ready=0 for 10 cycles in DONE; start pulsed -> resp_valid and resp
//      held, start ignored; ready=1 -> IDLE next cycle.
//   5. reset low during FIRE -> In=0, arb_reset=1, resp_valid=0 immediately;
//      after release, start yields a correct full word.
//   6. PUF_MAJORITY_VOTE_EN, VOTE_N=5, puf_out pattern 1,1,0,1,0 per repeat ->
//      bit=1; pattern 0,1,0,1,0 -> bit=0.

Source files
------------

// File: rtl/puf_challenge_driver.sv
// Arbiter-PUF sequencer: LFSR challenge, arbiter reset/launch timing, synchronised sampling, response packing. Optional PUF_MAJORITY_VOTE_EN.
// Latency: start accepted -> resp_valid after RESP_BITS*(SETUP_CYC+SETTLE_CYC+1) cycles (times VOTE_N with voting).
// Backpressure: resp/resp_valid held in DONE until resp_ready; start ignored whenever busy.
module puf_challenge_driver #(
  parameter int CHAL_W     = 16,
  parameter int RESP_BITS  = 8,
  parameter int SETUP_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int VOTE_N     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    seed,
  output logic [CHAL_W-1:0]    Challenge,
  output logic                 In,
  output logic                 arb_reset,
  input  logic                 puf_out,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
);

  localparam int PH_MAX = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int BIT_W  = $clog2(RESP_BITS);
  localparam logic [PH_W-1:0]   SETUP_LAST  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_BITS - 1);
  localparam logic [CHAL_W-1:0] ZERO_SUB    = CHAL_W'(16'hACE1);

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, SAMPLE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CHAL_W-1:0]      lfsr_q, lfsr_d;
  logic [CHAL_W-1:0]      chal_q, chal_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]        ph_cnt_q, ph_cnt_d;
  logic [RESP_BITS-1:0]   resp_sr_q, resp_sr_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic                   in_q, in_d;
  logic                   arb_q, arb_d;
  logic                   vld_q, vld_d;
  logic                   puf_m_q, puf_s_q;
  logic                   eval_last;
  logic                   new_bit;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VOTE_W = $clog2(VOTE_N + 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST = VOTE_W'(VOTE_N - 1);
  localparam logic [VOTE_W-1:0] VOTE_HALF = VOTE_W'(VOTE_N / 2);
  logic [VOTE_W-1:0] vote_cnt_q, vote_cnt_d;
  logic [VOTE_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [VOTE_W-1:0] ones_sum;
`endif

  // Fixed 16-bit Fibonacci tap set matching the arbiter chain width.
  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] v);
    return {v[CHAL_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign Challenge  = chal_q;
  assign In         = in_q;
  assign arb_reset  = arb_q;
  assign resp       = resp_q;
  assign resp_valid = vld_q;
  assign busy       = (state_q != IDLE);

  // Two-flop synchroniser for the asynchronous arbiter output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      puf_m_q <= 1'b0;
      puf_s_q <= 1'b0;
    end else begin
      puf_m_q <= puf_out;
      puf_s_q <= puf_m_q;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= '0;
      chal_q    <= '0;
      bit_cnt_q <= '0;
      ph_cnt_q  <= '0;
      resp_sr_q <= '0;
      resp_q    <= '0;
      in_q      <= 1'b0;
      arb_q     <= 1'b1;
      vld_q     <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_cnt_q <= '0;
      ones_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      chal_q    <= chal_d;
      bit_cnt_q <= bit_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      resp_sr_q <= resp_sr_d;
      resp_q    <= resp_d;
      in_q      <= in_d;
      arb_q     <= arb_d;
      vld_q     <= vld_d;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_cnt_q <= vote_cnt_d;
      ones_cnt_q <= ones_cnt_d;
`endif
    end
  end

  // Next-state sequencing; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    resp_sr_d = resp_sr_q;
    eval_last = 1'b0;
    new_bit   = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
    vote_cnt_d = vote_cnt_q;
    ones_cnt_d = ones_cnt_q;
    ones_sum   = ones_cnt_q + VOTE_W'(puf_s_q);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_d    = (seed == '0) ? ZERO_SUB : seed;
          bit_cnt_d = '0;
          ph_cnt_d  = '0;
`ifdef PUF_MAJORITY_VOTE_EN
          vote_cnt_d = '0;
          ones_cnt_d = '0;
`endif
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (ph_cnt_q == SETUP_LAST) begin
          ph_cnt_d = '0;
          state_d  = FIRE;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      FIRE: begin
        if (ph_cnt_q == SETTLE_LAST) begin
          ph_cnt_d = '0;
          state_d  = SAMPLE;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
        if (vote_cnt_q == VOTE_LAST) begin
          vote_cnt_d = '0;
          ones_cnt_d = '0;
          eval_last  = 1'b1;
          new_bit    = (ones_sum > VOTE_HALF);
        end else begin
          vote_cnt_d = vote_cnt_q + 1'b1;
          ones_cnt_d = ones_sum;
        end
`else
        eval_last = 1'b1;
        new_bit   = puf_s_q;
`endif
        state_d = LOAD;
        if (eval_last) begin
          resp_sr_d = {resp_sr_q[RESP_BITS-2:0], new_bit};
          lfsr_d    = lfsr_next(lfsr_q);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Challenge only moves on LOAD entry, so it is never disturbed while In is high.
    chal_d = ((state_d == LOAD) && (state_q != LOAD)) ? lfsr_d : chal_q;
    resp_d = ((state_d == DONE) && (state_q != DONE)) ? resp_sr_d : resp_q;
    in_d   = (state_d == FIRE);
    arb_d  = (state_d != FIRE);
    vld_d  = (state_d == DONE);
  end

endmodule

// File: tb/tb_puf_challenge_driver.sv
module tb_puf_challenge_driver;

  localparam int RB = 8;
  localparam int SU = 4;
  localparam int ST = 8;
  localparam int P  = SU + ST + 1;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VN = 5;
`else
  localparam int VN = 1;
`endif
  localparam int NEV = RB * VN;
  localparam int LIM = NEV * P + 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        resp_ready = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [15:0] Challenge;
  logic        In, arb_reset, puf_out, resp_valid, busy;
  logic [7:0]  resp;

  int   checks = 0;
  int   failures = 0;
  int   mode = 0;      // 0: constant puf_v, 1: puf_out follows Challenge[15], 2: per-evaluation values
  logic puf_v = 1'b0;
  bit   cmp_en = 1'b0;
  bit   pq[$];         // preset per-evaluation values for mode 2
  bit   evq[$];        // values actually presented, one per evaluation

  // model state
  bit          m_busy = 0, m_done = 0;
  int          m_m = 0, m_ones = 0;
  logic [15:0] m_lfsr = 0, m_chal = 0;
  logic [7:0]  m_sr = 0, m_resp = 0;

  assign puf_out = (mode == 1) ? Challenge[15] : puf_v;

  always #5 clk = ~clk;

  puf_challenge_driver #(
    .CHAL_W(16), .RESP_BITS(RB), .SETUP_CYC(SU), .SETTLE_CYC(ST), .VOTE_N(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .Challenge(Challenge), .In(In), .arb_reset(arb_reset), .puf_out(puf_out),
    .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy)
  );

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [7:0] msb_word(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0]  w;
    l = (s == 16'h0) ? 16'hACE1 : s;
    w = 8'h0;
    for (int i = 0; i < RB; i++) begin
      w = {w[6:0], l[15]};
      l = step(l);
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural timeline model: each evaluation is P cycles (setup, settle, sample).
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_busy = 0; m_done = 0; m_m = 0; m_ones = 0;
        m_chal = 16'h0; m_resp = 8'h0; m_sr = 8'h0;
        evq.delete();
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_m = 0; m_ones = 0;
          m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
          m_chal = m_lfsr;
        end
      end else if (m_done) begin
        if (resp_ready) begin
          m_busy = 0; m_done = 0;
        end
      end else begin
        if (m_m % P == P - 1) begin
          bit v;
          if (mode == 1) v = m_chal[15];
          else begin
            chk("eval_presented", evq.size() > 0, 1);
            v = (evq.size() > 0) ? evq.pop_front() : 1'b0;
          end
          m_ones += v;
          if ((m_m / P) % VN == VN - 1) begin
            m_sr   = {m_sr[6:0], (m_ones > VN / 2)};
            m_ones = 0;
            m_lfsr = step(m_lfsr);
          end
        end
        m_m++;
        if (m_m == NEV * P) begin
          m_done = 1;
          m_resp = m_sr;
        end else if (m_m % P == 0) begin
          m_chal = m_lfsr;
        end
      end
    end
  end

  // Per-evaluation puf value source; records what was presented for the model.
  initial begin
    logic in_prev;
    in_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (In === 1'b1 && !in_prev && mode != 1) begin
        if (mode == 2) puf_v = (pq.size() > 0) ? pq.pop_front() : 1'($urandom_range(0, 1));
        evq.push_back(puf_v);
      end
      in_prev = (In === 1'b1);
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic e_in;
        e_in = m_busy && !m_done && (m_m % P >= SU) && (m_m % P < SU + ST);
        chk("In", In, e_in);
        chk("arb_reset", arb_reset, !e_in);
        chk("busy", busy, m_busy);
        chk("resp_valid", resp_valid, m_done);
        chk("Challenge", Challenge, m_chal);
        chk("resp", resp, m_resp);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [15:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input bit jitter, output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < LIM) begin
      start = jitter ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (resp_valid !== 1'b1) chk("resp_valid_timeout", 0, 1);
  endtask

  task automatic accept(input int hold);
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [15:0] s;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_In", In, 0);
    chk("rst_arb_reset", arb_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_Challenge", Challenge, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // all-ones response and latency
    mode = 0; puf_v = 1'b1;
    do_start(16'h1234);
    chk("first_chal_seed", Challenge, 16'h1234);
    wait_valid(0, cyc);
    chk("latency", cyc + 1, 1 + NEV * P);
    chk("resp_ones", resp, 8'hFF);
    accept(0);

    // zero seed substitution and launch timing
    mode = 0; puf_v = 1'b0;
    do_start(16'h0000);
    chk("chal_zero_seed", Challenge, 16'hACE1);
    chk("setup_In_low", In, 0);
    repeat (SU) @(negedge clk);
    chk("fire_In_high", In, 1);
    chk("fire_arb_low", arb_reset, 0);
    repeat (ST) @(negedge clk);
    chk("sample_In_low", In, 0);
    repeat (VN * P - SU - ST) @(negedge clk);
    chk("second_chal", Challenge, 16'h59C3);
    wait_valid(0, cyc);
    chk("resp_zeros", resp, 8'h00);
    accept(1);

    // response follows challenge MSB sequence
    mode = 1;
    s = 16'($urandom);
    do_start(s);
    wait_valid(1, cyc);
    chk("resp_msb_seq", resp, msb_word(s));
    accept(2);

    // preset evaluation pattern, then hold in DONE with start ignored
    mode = 2;
    pq.delete();
    for (int b = 0; b < RB; b++) begin
`ifdef PUF_MAJORITY_VOTE_EN
      bit pat_a[5] = '{1, 1, 0, 1, 0};
      bit pat_b[5] = '{0, 1, 0, 1, 0};
      for (int r = 0; r < VN; r++) pq.push_back((b % 2 == 0) ? pat_a[r] : pat_b[r]);
`else
      bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      pq.push_back(pat[b]);
`endif
    end
    do_start(16'hBEEF);
    wait_valid(0, cyc);
`ifdef PUF_MAJORITY_VOTE_EN
    chk("resp_vote_pattern", resp, 8'hAA);
`else
    chk("resp_pattern", resp, 8'hB2);
`endif
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_valid", resp_valid, 1);
    chk("held_busy", busy, 1);
    resp_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    start = 1'b0;
    chk("hs_idle_valid", resp_valid, 0);
    chk("hs_idle_busy", busy, 0);
    @(negedge clk);
    chk("hs_start_ignored", busy, 0);

    // reset mid-FIRE aborts, then a clean word
    mode = 0; puf_v = 1'b1;
    do_start(16'h0F0F);
    cyc = 0;
    while (In !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_fire", In, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_In", In, 0);
    chk("abort_arb_reset", arb_reset, 1);
    chk("abort_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    mode = 1;
    s = 16'hC3A5;
    do_start(s);
    wait_valid(0, cyc);
    chk("post_reset_word", resp, msb_word(s));
    accept(0);

    // randomized words
    for (int n = 0; n < 8; n++) begin
      mode  = $urandom_range(1, 2);
      puf_v = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      do_start(s);
      wait_valid(1, cyc);
      if (mode == 1) chk("rand_msb_seq", resp, msb_word(s));
      accept($urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
